// File: rtl/mem_ctrl_pkg.sv
// Shared types for mem_ctrl: FSM state encoding, access-length codes and the
// length-to-byte-count helper.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    MEM_IDLE,
    MEM_INST_RD,
    MEM_DATA_RD,
    MEM_DATA_WR,
    MEM_DONE
  } mem_state_e;

  typedef enum logic {
    REQ_INST,
    REQ_DATA
  } req_id_e;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial controller sharing one RAM between inst_cache refills and MEM-stage
// loads/stores. Define MEMCTRL_IO_FULL_EN to add io_buffer_full store back-pressure.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR = ADDR_WIDTH'(32'h30000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef MEMCTRL_IO_FULL_EN
  input  logic                  io_buffer_full,
`endif
  input  logic                  inst_port_calling,
  input  logic [ADDR_WIDTH-1:0] inst_addr_to_mem,
  output logic                  inst_available,
  output logic [31:0]           inst_from_mem,
  input  logic                  data_calling,
  input  logic                  data_we,
  input  logic [1:0]            data_len,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  output logic                  data_done,
  output logic [31:0]           data_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  mem_state_e            state, state_nxt;
  req_id_e               req_q;
  logic [2:0]            cnt, len_n;
  logic [ADDR_WIDTH-1:0] base_q, cur_addr;
  logic [31:0]           wdata_q, word_q, word_nxt;
  logic [1:0]            cap_idx;
  logic                  accept, cnt_inc, capture;
  logic                  io_full, io_hit, io_stall;

`ifdef MEMCTRL_IO_FULL_EN
  localparam logic IO_STALL_EN = 1'b1;
  assign io_full = io_buffer_full;
`else
  localparam logic IO_STALL_EN = 1'b0;
  assign io_full = 1'b0;
`endif

  assign cur_addr = base_q + ADDR_WIDTH'(cnt);
  assign io_hit   = (cur_addr == IO_ADDR) || (cur_addr == IO_ADDR + ADDR_WIDTH'(4));
  assign io_stall = IO_STALL_EN && io_hit && io_full;

  // RAM returns the byte one cycle after its address, so cnt lags by one on capture
  assign cap_idx = cnt[1:0] - 2'd1;

  always_comb begin
    word_nxt = word_q;
    word_nxt[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    cnt_inc        = 1'b0;
    capture        = 1'b0;
    mem_a          = '0;
    mem_dout       = '0;
    mem_wr         = 1'b0;
    inst_available = 1'b0;
    data_done      = 1'b0;
    unique case (state)
      MEM_IDLE: begin
        if (data_calling) begin
          accept    = 1'b1;
          state_nxt = data_we ? MEM_DATA_WR : MEM_DATA_RD;
        end else if (inst_port_calling) begin
          accept    = 1'b1;
          state_nxt = MEM_INST_RD;
        end
      end
      MEM_INST_RD, MEM_DATA_RD: begin
        // A dropped fetch request is a branch flush: abandon without a pulse
        if (state == MEM_INST_RD && !inst_port_calling) begin
          state_nxt = MEM_IDLE;
        end else begin
          if (cnt < len_n) mem_a = cur_addr;
          capture = (cnt != 3'd0);
          if (cnt == len_n) state_nxt = MEM_DONE;
          else              cnt_inc   = 1'b1;
        end
      end
      MEM_DATA_WR: begin
        mem_a    = cur_addr;
        mem_dout = wdata_q[{cnt[1:0], 3'b000} +: 8];
        if (!io_stall) begin
          mem_wr = 1'b1;
          if (cnt == len_n - 3'd1) state_nxt = MEM_DONE;
          else                     cnt_inc   = 1'b1;
        end
      end
      MEM_DONE: begin
        state_nxt      = MEM_IDLE;
        inst_available = (req_q == REQ_INST);
        data_done      = (req_q == REQ_DATA);
      end
      default: state_nxt = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= MEM_IDLE;
      cnt           <= '0;
      len_n         <= 3'd4;
      req_q         <= REQ_INST;
      inst_from_mem <= '0;
      data_rdata    <= '0;
    end else begin
      state <= state_nxt;
      if (accept)       cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 3'd1;
      if (accept) begin
        len_n <= data_calling ? len_to_n(data_len) : 3'd4;
        req_q <= data_calling ? REQ_DATA : REQ_INST;
      end
      if (capture && cnt == len_n) begin
        if (req_q == REQ_INST) inst_from_mem <= word_nxt;
        else                   data_rdata    <= word_nxt;
      end
    end
  end

  // Datapath latches carry no reset; they are always reloaded at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q  <= data_calling ? data_addr : inst_addr_to_mem;
      wdata_q <= data_wdata;
      word_q  <= '0;
    end else if (capture) begin
      word_q  <= word_nxt;
    end
  end

endmodule
